// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that checks per-source header sequence numbers and LFSR payloads,
// with optional pseudo-random backpressure, saturating counters and first-error capture.
module axis_stream_checker #(
   parameter int          TDATAW         = 32,
   parameter int          TDESTW         = 4,
   parameter int          NUM_SRC        = 4,
   parameter int          MY_ADDR        = 0,
   parameter logic [31:0] LFSR_DEFAULT   = 32'hACE1_2345,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLEAR,
   input  logic              STALL_EN,
   input  logic              AXIS_S_TVALID,
   output logic              AXIS_S_TREADY,
   input  logic [TDATAW-1:0] AXIS_S_TDATA,
   input  logic              AXIS_S_TLAST,
   input  logic [TDESTW-1:0] AXIS_S_TDEST,
   output logic [31:0]       PKT_COUNT,
   output logic [31:0]       FLIT_COUNT,
   output logic [15:0]       ERR_COUNT,
   output logic              ERR_FLAG,
   output logic [2:0]        ERR_CODE,
   output logic [TDATAW-1:0] ERR_DATA
);

   localparam int SRC_IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TDESTW:0]   NUM_SRC_L = (TDESTW+1)'(NUM_SRC);
   localparam logic [TDESTW-1:0] MY_ADDR_L = TDESTW'(MY_ADDR);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DISCARD} state_e;

   function automatic logic [31:0] src_lfsr_next(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   state_e              state_q, state_d;
   logic                ready_en_q;
   logic                tready_q, tready_d;
   logic [7:0]          bp_q, bp_d;
   logic [31:0]         lfsr_q    [NUM_SRC];
   logic [31:0]         lfsr_d    [NUM_SRC];
   logic [15:0]         exp_seq_q [NUM_SRC];
   logic [15:0]         exp_seq_d [NUM_SRC];
   logic [SRC_IW-1:0]   src_q, src_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [31:0]         pkt_q, pkt_d;
   logic [31:0]         flit_q, flit_d;
   logic [15:0]         err_cnt_q, err_cnt_d;
   logic                err_flag_q, err_flag_d;
   logic [2:0]          err_code_q, err_code_d;
   logic [TDATAW-1:0]   err_data_q, err_data_d;

   logic                accept;
   logic [TDESTW-1:0]   hdr_src;
   logic [SRC_IW-1:0]   hdr_idx;
   logic [15:0]         hdr_seq;
   logic                src_bad;
   logic                timeout;
   logic                e_data, e_seq, e_src, e_dest, err_any;
   logic [2:0]          err_code_now;

   assign accept  = AXIS_S_TVALID & tready_q;
   assign hdr_src = AXIS_S_TDATA[TDESTW-1:0];
   assign hdr_idx = hdr_src[SRC_IW-1:0];
   assign hdr_seq = AXIS_S_TDATA[31:16];
   assign src_bad = {1'b0, hdr_src} >= NUM_SRC_L;
   assign timeout = (state_q != ST_IDLE) && !accept && (timer_q == TMR_LAST);

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (RST)        state_q <= ST_IDLE;
      else if (CLEAR) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      state_d = state_q;
      if (timeout) begin
         state_d = ST_IDLE;
      end else if (accept) begin
         unique case (state_q)
            ST_IDLE:    if (!AXIS_S_TLAST) state_d = src_bad ? ST_DISCARD : ST_PAYLOAD;
            ST_PAYLOAD,
            ST_DISCARD: if (AXIS_S_TLAST)  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // Error classification for the flit presented this cycle
   always_comb begin
      e_data = accept && (state_q == ST_PAYLOAD) && (AXIS_S_TDATA[31:0] != lfsr_q[src_q]);
      e_seq  = accept && (state_q == ST_IDLE) && !src_bad && (hdr_seq != exp_seq_q[hdr_idx]);
      e_src  = accept && (state_q == ST_IDLE) && src_bad;
      e_dest = accept && (AXIS_S_TDEST != MY_ADDR_L);
      err_any = e_data | e_seq | e_src | e_dest | timeout;
      if      (e_data) err_code_now = 3'd1;
      else if (e_seq)  err_code_now = 3'd2;
      else if (e_src)  err_code_now = 3'd3;
      else if (e_dest) err_code_now = 3'd4;
      else             err_code_now = 3'd5;
   end

   // FSM outputs and datapath next state
   always_comb begin
      bp_d       = {bp_q[6:0], bp_q[7] ^ bp_q[5] ^ bp_q[4] ^ bp_q[3]};
      tready_d   = ready_en_q & (~STALL_EN | (bp_q[1:0] != 2'b00));
      lfsr_d     = lfsr_q;
      exp_seq_d  = exp_seq_q;
      src_d      = src_q;
      pkt_d      = pkt_q;
      flit_d     = flit_q;
      err_cnt_d  = err_cnt_q;
      err_flag_d = err_flag_q;
      err_code_d = err_code_q;
      err_data_d = err_data_q;
      timer_d    = (state_q == ST_IDLE || accept || timeout) ? '0 : timer_q + TMR_W'(1);

      if (accept) begin
         if (state_q == ST_IDLE && !src_bad) begin
            exp_seq_d[hdr_idx] = hdr_seq + 16'd1;
            src_d              = hdr_idx;
         end
         if (state_q == ST_PAYLOAD)
            lfsr_d[src_q] = src_lfsr_next(lfsr_q[src_q]);
         if (flit_q != '1)                   flit_d = flit_q + 32'd1;
         if (AXIS_S_TLAST && pkt_q != '1)    pkt_d  = pkt_q + 32'd1;
      end

      if (err_any) begin
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
         if (!err_flag_q) begin
            err_flag_d = 1'b1;
            err_code_d = err_code_now;
            err_data_d = timeout ? '0 : AXIS_S_TDATA;
         end
      end
   end

   // Datapath registers; CLEAR behaves exactly like reset and drops any concurrent flit
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: the per-source tables are a handful of flops, not RAM, so they take the reset.
      if (RST || CLEAR) begin
         ready_en_q <= 1'b0;
         tready_q   <= 1'b0;
         bp_q       <= 8'hFF;
         for (int i = 0; i < NUM_SRC; i++) begin
            lfsr_q[i]    <= LFSR_DEFAULT;
            exp_seq_q[i] <= '0;
         end
         src_q      <= '0;
         timer_q    <= '0;
         pkt_q      <= '0;
         flit_q     <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
         err_code_q <= '0;
         err_data_q <= '0;
      end else begin
         ready_en_q <= 1'b1;
         tready_q   <= tready_d;
         bp_q       <= bp_d;
         lfsr_q     <= lfsr_d;
         exp_seq_q  <= exp_seq_d;
         src_q      <= src_d;
         timer_q    <= timer_d;
         pkt_q      <= pkt_d;
         flit_q     <= flit_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
         err_code_q <= err_code_d;
         err_data_q <= err_data_d;
      end
   end

   assign AXIS_S_TREADY = tready_q;
   assign PKT_COUNT     = pkt_q;
   assign FLIT_COUNT    = flit_q;
   assign ERR_COUNT     = err_cnt_q;
   assign ERR_FLAG      = err_flag_q;
   assign ERR_CODE      = err_code_q;
   assign ERR_DATA      = err_data_q;

endmodule
